jb_aes128_encrypt_iter: RTL and testbench

//  Iterative AES-128 encryptor with full on-the-fly key expansion and valid/ready handshakes on both sides.

---
 rtl/jb_aes_pkg.sv | 40 ++++
 rtl/jb_aes128_round_unit.sv | 32 +++
 rtl/jb_aes128_encrypt_iter.sv | 97 +++++++++
 tb/tb_jb_aes128_encrypt_iter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/jb_aes_pkg.sv
// jb_aes_pkg: shared AES-128 types, round constants and byte-level helpers
// Types: block128_t (state/key as [col][row] bytes), roundconstants_t, aes_iter_state_t.
// Functions: xtime, gmul, sbox, bus_to_block, block_to_bus.
package jb_aes_pkg;
  // [col][row]; element [0][0] sits in bits [127:120], so bus byte k lands on col k/4, row k%4
  typedef logic [0:3][0:3][7:0] block128_t;
  typedef logic [9:0][7:0] roundconstants_t;
  localparam roundconstants_t RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_iter_state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // GF(2^8) inverse as b^254 (0 maps to 0), followed by the FIPS-197 affine transform
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p, r;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic block128_t bus_to_block(input logic [127:0] b);
    return block128_t'(b);
  endfunction
  function automatic logic [127:0] block_to_bus(input block128_t b);
    return 128'(b);
  endfunction
endpackage

// File: rtl/jb_aes128_round_unit.sv
// jb_aes128_round_unit: one combinational AES-128 round with its key-schedule step
// Ports: state_i/rk_i current state and round key, rcon_i round constant, last_i skips MixColumns,
//        state_o/rk_o state and round key after this round.
module jb_aes128_round_unit
  import jb_aes_pkg::*;
(
  input  block128_t  state_i,
  input  block128_t  rk_i,
  input  logic [7:0] rcon_i,
  input  logic       last_i,
  output block128_t  state_o,
  output block128_t  rk_o
);
  block128_t sr, mc, nk;
  always_comb begin
    sr = '0;
    mc = '0;
    nk = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[c][r] = sbox(state_i[(c + r) % 4][r]);
    nk[0] = rk_i[0] ^ {sbox(rk_i[3][1]) ^ rcon_i, sbox(rk_i[3][2]), sbox(rk_i[3][3]), sbox(rk_i[3][0])};
    for (int c = 1; c < 4; c++)
      nk[c] = nk[c-1] ^ rk_i[c];
    // 2a^3b^c^d written as xtime(a^b)^b^c^d
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mc[c][r] = xtime(sr[c][r] ^ sr[c][(r + 1) % 4]) ^ sr[c][(r + 1) % 4] ^ sr[c][(r + 2) % 4] ^ sr[c][(r + 3) % 4];
    state_o = (last_i ? sr : mc) ^ nk;
    rk_o = nk;
  end
endmodule

// File: rtl/jb_aes128_encrypt_iter.sv
// jb_aes128_encrypt_iter: iterative AES-128 encryptor with on-the-fly key expansion and valid/ready on both sides
// Ports: clk, nRst (sync active-low); in_valid/in_ready/in_key/in_block/in_tag job input;
//        out_valid/out_ready/out_block/out_tag ciphertext output.
// Config: JB_AES_ZEROIZE_EN clears state, round key and tag registers on retire.
module jb_aes128_encrypt_iter
  import jb_aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_key,
  input  logic [127:0]     in_block,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [TAG_W-1:0] out_tag
);
`ifdef JB_AES_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif
  localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);
  aes_iter_state_t fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  block128_t state_q, state_d, rk_q, rk_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  block128_t st [ROUNDS_PER_CYCLE+1];
  block128_t kk [ROUNDS_PER_CYCLE+1];
  logic fin;
  assign st[0] = state_q;
  assign kk[0] = rk_q;
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
    logic [3:0] rn;
    logic [7:0] rc;
    assign rn = rnd_q + 4'(j);
    assign rc = (rn >= 4'd1 && rn <= 4'd10) ? RCON[rn - 4'd1] : 8'h00;
    jb_aes128_round_unit u_round (
      .state_i(st[j]),
      .rk_i(kk[j]),
      .rcon_i(rc),
      .last_i(rn == 4'd10),
      .state_o(st[j+1]),
      .rk_o(kk[j+1])
    );
  end
  // state_q holds the ciphertext in DONE, so it doubles as the output register
  assign out_valid = fsm_q == DONE;
  assign in_ready = fsm_q == IDLE || (fsm_q == DONE && out_ready);
  assign out_block = block_to_bus(state_q);
  assign out_tag = tag_q;
  assign fin = rnd_q + RPC == 4'd11;
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    state_d = state_q;
    rk_d = rk_q;
    tag_d = tag_q;
    if (in_valid && in_ready) begin
      fsm_d = RUN;
      rnd_d = 4'd1;
      state_d = bus_to_block(in_block ^ in_key);
      rk_d = bus_to_block(in_key);
      tag_d = in_tag;
    end else if (fsm_q == DONE && out_ready) begin
      fsm_d = IDLE;
      state_d = ZEROIZE ? '0 : state_q;
      rk_d = ZEROIZE ? '0 : rk_q;
      tag_d = ZEROIZE ? '0 : tag_q;
    end else if (fsm_q == RUN) begin
      fsm_d = fin ? DONE : RUN;
      rnd_d = fin ? 4'd0 : rnd_q + RPC;
      state_d = st[ROUNDS_PER_CYCLE];
      rk_d = kk[ROUNDS_PER_CYCLE];
    end
  end
  always_ff @(posedge clk) begin
    if (!nRst) begin
      fsm_q <= IDLE;
      rnd_q <= 4'd0;
      state_q <= '0;
      rk_q <= '0;
      tag_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      state_q <= state_d;
      rk_q <= rk_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_jb_aes128_encrypt_iter.sv
// tb_jb_aes128_encrypt_iter: directed FIPS-197 vectors across all legal ROUNDS_PER_CYCLE values
module tb_jb_aes128_encrypt_iter;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam int EXP_LAT [4] = '{10, 5, 2, 1};
  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] in_key = '0;
  logic [127:0] in_block = '0;
  logic [7:0] in_tag = '0;
  logic [3:0] ir, ov;
  logic [127:0] ob [4];
  logic [7:0] ot [4];
  logic [127:0] exp_hold;
  logic seen;
  int pass = 0;
  int total = 0;
  int lat [4];
  int n;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    jb_aes128_encrypt_iter #(
      .ROUNDS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10),
      .TAG_W(8)
    ) dut (
      .clk(clk),
      .nRst(nRst),
      .in_valid(in_valid),
      .in_ready(ir[g]),
      .in_key(in_key),
      .in_block(in_block),
      .in_tag(in_tag),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_block(ob[g]),
      .out_tag(ot[g])
    );
  end
  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask
  task automatic offer(input logic [127:0] k, input logic [127:0] p, input logic [7:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    in_key = k;
    in_block = p;
    in_tag = t;
    chk("offer_in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_key = ~k;
    in_block = '1;
    in_tag = ~t;
  endtask
  task automatic measure();
    for (int d = 0; d < 4; d++) lat[d] = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++)
        if (ov[d] && lat[d] == 0) lat[d] = i;
    end
  endtask
  task automatic wait_ov(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (ov[0]) begin
        cyc = i;
        break;
      end
    end
  endtask
  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_out_block", ob[0], 128'd0);
    chk("rst_out_tag", 128'(ot[0]), 128'd0);
    chk("rst_in_ready", 128'(ir[0]), 128'd1);
    nRst = 1'b1;
    offer(K1, P1, 8'h11);
    measure();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("c1_lat_%0d", d), 128'(lat[d]), 128'(EXP_LAT[d]));
      chk($sformatf("c1_ct_%0d", d), ob[d], C1);
      chk($sformatf("c1_tag_%0d", d), 128'(ot[d]), 128'h11);
    end
    retire();
    offer(K2, P2, 8'h22);
    measure();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("b_lat_%0d", d), 128'(lat[d]), 128'(EXP_LAT[d]));
      chk($sformatf("b_ct_%0d", d), ob[d], C2);
    end
    chk("bp_out_valid", 128'(ov[0]), 128'd1);
    chk("bp_out_block", ob[0], C2);
    chk("bp_out_tag", 128'(ot[0]), 128'h22);
    chk("bp_in_ready", 128'(ir[0]), 128'd0);
    retire();
    chk("retire_out_valid", 128'(ov[0]), 128'd0);
    chk("retire_in_ready", 128'(ir[0]), 128'd1);
`ifdef JB_AES_ZEROIZE_EN
    exp_hold = '0;
    chk("zero_state", 128'(g_dut[0].dut.state_q), 128'd0);
    chk("zero_rk", 128'(g_dut[0].dut.rk_q), 128'd0);
`else
    exp_hold = C2;
`endif
    chk("post_retire_block", ob[0], exp_hold);
    @(posedge clk);
    #1;
    chk("single_retire", 128'(ov[0]), 128'd0);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_key = K1;
    in_block = P1;
    in_tag = 8'hA1;
    @(posedge clk);
    #1;
    in_key = K2;
    in_block = P2;
    in_tag = 8'hA2;
    wait_ov(n);
    chk("b2b_lat1", 128'(n), 128'd10);
    chk("b2b_ct1", ob[0], C1);
    chk("b2b_tag1", 128'(ot[0]), 128'hA1);
    chk("b2b_in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_no_bubble", 128'(ov[0]), 128'd0);
    wait_ov(n);
    chk("b2b_lat2", 128'(n), 128'd10);
    chk("b2b_ct2", ob[0], C2);
    chk("b2b_tag2", 128'(ot[0]), 128'hA2);
    @(posedge clk);
    #1;
    chk("b2b_retire2", 128'(ov[0]), 128'd0);
    out_ready = 1'b0;
    offer(K1, P1, 8'h55);
    repeat (5) @(posedge clk);
    @(negedge clk);
    nRst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", 128'(ov[0]), 128'd0);
    chk("abort_in_ready", 128'(ir[0]), 128'd1);
    chk("abort_out_block", ob[0], 128'd0);
    @(negedge clk);
    nRst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen = seen | ov[0];
    end
    chk("abort_no_output", 128'(seen), 128'd0);
    offer(K2, P2, 8'h66);
    wait_ov(n);
    chk("after_abort_lat", 128'(n), 128'd10);
    chk("after_abort_ct", ob[0], C2);
    chk("after_abort_tag", 128'(ot[0]), 128'h66);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
